lc_request_assembler: RTL and testbench

Host-facing front end for the lifecycle path of the MCSE control unit. It assembles a 256-bit lifecycle transition ID and a 256-bit authentication ID from 32-bit host words (GPIO-side word handshake). On a commit command it drives `lc_transition_id`/`lc_transition_request_in` and `lc_authentication_id`/`lc_authentication_valid` into the control unit, then zeroizes its key material. Malformed command sequences latch an error until the host aborts.

---
 rtl/lc_request_assembler.sv | 166 ++++++++++++++++
 tb/tb_lc_request_assembler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lc_request_assembler.sv
// Lifecycle request assembler: collects host words into transition/auth IDs,
// then issues a one-cycle request, a held auth strobe, and zeroizes on exit.
module lc_request_assembler #(
    parameter int WORD_W    = 32,
    parameter int ID_W      = 256,
    parameter int AUTH_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [1:0]        host_cmd,
    input  logic [WORD_W-1:0] host_data,
    output logic [ID_W-1:0]   lc_transition_id,
    output logic              lc_transition_request_in,
    output logic [ID_W-1:0]   lc_authentication_id,
    output logic              lc_authentication_valid,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code
);
    localparam int NWORDS = ID_W / WORD_W;
    localparam int CNT_W  = $clog2(NWORDS + 1);
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int HOLD_W = (AUTH_HOLD > 1) ? $clog2(AUTH_HOLD) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NWORDS);

    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_AUTH, ST_CLEAR, ST_ERR} state_t;

    state_t              state_reg;
    logic [WORD_W-1:0]   tid_words [NWORDS];
    logic [WORD_W-1:0]   auth_words [NWORDS];
    logic [CNT_W-1:0]    tid_cnt_reg, auth_cnt_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic [ID_W-1:0]     tid_id_reg, auth_id_reg, tid_flat, auth_flat;
    logic                req_reg, auth_valid_reg, ready_reg, busy_reg, err_reg;
    logic [1:0]          err_code_reg;
    logic                xfer, enter_clear;

    // Word 0 lands in the least significant slice of each ID.
    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_pack
            assign tid_flat[gi*WORD_W +: WORD_W]  = tid_words[gi];
            assign auth_flat[gi*WORD_W +: WORD_W] = auth_words[gi];
        end
    endgenerate

    assign xfer = host_valid && ready_reg;

    always_comb begin
        enter_clear = 1'b0;
        if (xfer && host_cmd == 2'b11 && (state_reg == ST_IDLE || state_reg == ST_ERR))
            enter_clear = 1'b1;
        if (state_reg == ST_AUTH && hold_cnt_reg == '0)
            enter_clear = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            tid_cnt_reg    <= '0;
            auth_cnt_reg   <= '0;
            hold_cnt_reg   <= '0;
            tid_id_reg     <= '0;
            auth_id_reg    <= '0;
            req_reg        <= 1'b0;
            auth_valid_reg <= 1'b0;
            ready_reg      <= 1'b1;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
            err_code_reg   <= 2'b00;
            for (int i = 0; i < NWORDS; i++) begin
                tid_words[i]  <= '0;
                auth_words[i] <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (xfer) begin
                        case (host_cmd)
                            2'b00: begin
                                if (tid_cnt_reg == FULL) begin
                                    state_reg    <= ST_ERR;
                                    err_reg      <= 1'b1;
                                    err_code_reg <= 2'b01;
                                end else begin
                                    tid_words[tid_cnt_reg[IDX_W-1:0]] <= host_data;
                                    tid_cnt_reg <= tid_cnt_reg + CNT_W'(1);
                                end
                            end
                            2'b01: begin
                                if (auth_cnt_reg == FULL) begin
                                    state_reg    <= ST_ERR;
                                    err_reg      <= 1'b1;
                                    err_code_reg <= 2'b01;
                                end else begin
                                    auth_words[auth_cnt_reg[IDX_W-1:0]] <= host_data;
                                    auth_cnt_reg <= auth_cnt_reg + CNT_W'(1);
                                end
                            end
                            2'b10: begin
                                if (tid_cnt_reg == FULL && auth_cnt_reg == FULL) begin
                                    state_reg  <= ST_REQ;
                                    req_reg    <= 1'b1;
                                    tid_id_reg <= tid_flat;
                                    ready_reg  <= 1'b0;
                                    busy_reg   <= 1'b1;
                                end else begin
                                    state_reg    <= ST_ERR;
                                    err_reg      <= 1'b1;
                                    err_code_reg <= 2'b10;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_REQ: begin
                    state_reg      <= ST_AUTH;
                    req_reg        <= 1'b0;
                    auth_valid_reg <= 1'b1;
                    auth_id_reg    <= auth_flat;
                    hold_cnt_reg   <= HOLD_W'(AUTH_HOLD - 1);
                end
                ST_AUTH: begin
                    if (hold_cnt_reg != '0)
                        hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
                end
                ST_CLEAR: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end
                ST_ERR: ;
                default: state_reg <= ST_IDLE;
            endcase

            // Shared entry into CLEAR (abort or end of auth): drop outputs and key material.
            if (enter_clear) begin
                state_reg      <= ST_CLEAR;
                ready_reg      <= 1'b0;
                busy_reg       <= 1'b1;
                err_reg        <= 1'b0;
                err_code_reg   <= 2'b00;
                auth_valid_reg <= 1'b0;
                tid_id_reg     <= '0;
                auth_id_reg    <= '0;
                tid_cnt_reg    <= '0;
                auth_cnt_reg   <= '0;
                for (int i = 0; i < NWORDS; i++) begin
                    tid_words[i]  <= '0;
                    auth_words[i] <= '0;
                end
            end
        end
    end

    assign host_ready               = ready_reg;
    assign lc_transition_id         = tid_id_reg;
    assign lc_transition_request_in = req_reg;
    assign lc_authentication_id     = auth_id_reg;
    assign lc_authentication_valid  = auth_valid_reg;
    assign busy                     = busy_reg;
    assign err                      = err_reg;
    assign err_code                 = err_code_reg;
endmodule

// File: tb/tb_lc_request_assembler.sv
// Directed bench for lc_request_assembler: loads, commit timing, error paths,
// abort recovery and asynchronous reset during authentication.
module tb_lc_request_assembler;
    logic         clk = 1'b0;
    logic         rst;
    logic         host_valid;
    logic         host_ready;
    logic [1:0]   host_cmd;
    logic [31:0]  host_data;
    logic [255:0] lc_transition_id;
    logic         lc_transition_request_in;
    logic [255:0] lc_authentication_id;
    logic         lc_authentication_valid;
    logic         busy;
    logic         err;
    logic [1:0]   err_code;

    int n_cmp = 0;
    int n_bad = 0;

    lc_request_assembler #(.WORD_W(32), .ID_W(256), .AUTH_HOLD(4)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .host_valid               (host_valid),
        .host_ready               (host_ready),
        .host_cmd                 (host_cmd),
        .host_data                (host_data),
        .lc_transition_id         (lc_transition_id),
        .lc_transition_request_in (lc_transition_request_in),
        .lc_authentication_id     (lc_authentication_id),
        .lc_authentication_valid  (lc_authentication_valid),
        .busy                     (busy),
        .err                      (err),
        .err_code                 (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    // One host transfer; returns 1 ns after the accepting edge.
    task automatic do_xfer(input logic [1:0] cmd, input logic [31:0] data);
        int n;
        n = 0;
        @(negedge clk);
        while (!host_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!host_ready) check("ready_timeout", {255'd0, host_ready}, 256'd1);
        host_valid = 1'b1;
        host_cmd   = cmd;
        host_data  = data;
        @(posedge clk);
        #1;
        host_valid = 1'b0;
    endtask

    task automatic run_commit(input logic [255:0] exp_tid, input logic [255:0] exp_auth,
                              input bit hold_valid);
        do_xfer(2'b10, 32'h0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check($sformatf("c%0d_req", c),   {255'd0, lc_transition_request_in}, {255'd0, c == 1});
            check($sformatf("c%0d_aval", c),  {255'd0, lc_authentication_valid}, {255'd0, (c >= 2 && c <= 5)});
            check($sformatf("c%0d_tid", c),   lc_transition_id, (c <= 5) ? exp_tid : 256'd0);
            check($sformatf("c%0d_aid", c),   lc_authentication_id, (c >= 2 && c <= 5) ? exp_auth : 256'd0);
            check($sformatf("c%0d_busy", c),  {255'd0, busy}, {255'd0, c <= 6});
            check($sformatf("c%0d_ready", c), {255'd0, host_ready}, {255'd0, c == 7});
            if (hold_valid && c < 7) begin
                host_valid = 1'b1;
                host_cmd   = 2'b00;
                host_data  = 32'hFFFF_FFFF;
            end else begin
                host_valid = 1'b0;
            end
        end
    endtask

    task automatic load_std(input int n_tid, input int n_auth);
        for (int i = 0; i < n_tid; i++)  do_xfer(2'b00, 32'h1111_1111 * (i + 1));
        for (int i = 0; i < n_auth; i++) do_xfer(2'b01, 32'hA0 + i);
    endtask

    task automatic abort_and_wait();
        do_xfer(2'b11, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("abort_ready", {255'd0, host_ready}, 256'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] std_tid, std_auth, il_tid, il_auth;
        logic [15:0]  pattern;
        int tcnt, acnt, idx, guard;

        for (int i = 0; i < 8; i++) begin
            std_tid[i*32 +: 32]  = 32'h1111_1111 * (i + 1);
            std_auth[i*32 +: 32] = 32'hA0 + i;
        end

        rst = 1'b0;
        host_valid = 1'b0;
        host_cmd = 2'b00;
        host_data = 32'h0;
        #12;
        check("rst_ready", {255'd0, host_ready}, 256'd1);
        check("rst_busy",  {255'd0, busy}, 256'd0);
        check("rst_err",   {254'd0, err, err_code}, 256'd0);
        check("rst_tid",   lc_transition_id, 256'd0);
        check("rst_req",   {254'd0, lc_transition_request_in, lc_authentication_valid}, 256'd0);
        @(negedge clk);
        rst = 1'b1;

        // Nominal load and commit, host_valid held high throughout busy.
        load_std(8, 8);
        @(negedge clk);
        check("rest_tid", lc_transition_id, 256'd0);
        check("rest_aid", lc_authentication_id, 256'd0);
        run_commit(std_tid, std_auth, 1'b1);

        // Counts were cleared and nothing absorbed during busy: a full reload must not overflow.
        load_std(8, 8);
        @(negedge clk);
        check("reload_err", {253'd0, err, err_code}, 256'd0);
        run_commit(std_tid, std_auth, 1'b0);

        // Overflow on ninth TID word.
        load_std(8, 0);
        do_xfer(2'b00, 32'hDEAD_BEEF);
        @(negedge clk);
        check("ovf_err",  {255'd0, err}, 256'd1);
        check("ovf_code", {254'd0, err_code}, 256'd1);
        check("ovf_ready", {255'd0, host_ready}, 256'd1);
        do_xfer(2'b10, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("errcommit_c%0d", c),
                  {252'd0, lc_transition_request_in, lc_authentication_valid, busy, err}, 256'd1);
        end
        do_xfer(2'b11, 32'h0);
        @(negedge clk);
        check("abort_clear", {252'd0, host_ready, busy, err_code}, 256'h4);
        check("abort_err",   {255'd0, err}, 256'd0);
        @(negedge clk);
        check("abort_idle",  {254'd0, host_ready, busy}, 256'h2);
        load_std(8, 0);
        @(negedge clk);
        check("post_abort_cnt", {255'd0, err}, 256'd0);
        abort_and_wait();

        // Incomplete commit: 8 TID, 5 AUTH.
        load_std(8, 5);
        do_xfer(2'b10, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("inc_c%0d_err", c), {253'd0, err, err_code}, 256'h6);
            check($sformatf("inc_c%0d_strobe", c),
                  {254'd0, lc_transition_request_in, lc_authentication_valid}, 256'd0);
        end
        abort_and_wait();

        // Interleaved loads with random host_valid gaps.
        pattern = 16'b1010_0110_1100_1001;
        tcnt = 0;
        acnt = 0;
        idx = 0;
        guard = 0;
        while (idx < 16 && guard < 500) begin
            @(negedge clk);
            guard++;
            host_cmd  = pattern[idx] ? 2'b01 : 2'b00;
            host_data = pattern[idx] ? (32'hBEEF_0000 + acnt) : (32'hC0DE_0000 + tcnt);
            host_valid = 1'($urandom_range(1, 0));
            if (host_valid && host_ready) begin
                if (pattern[idx]) begin
                    il_auth[acnt*32 +: 32] = 32'hBEEF_0000 + acnt;
                    acnt++;
                end else begin
                    il_tid[tcnt*32 +: 32] = 32'hC0DE_0000 + tcnt;
                    tcnt++;
                end
                idx++;
            end
        end
        @(negedge clk);
        host_valid = 1'b0;
        check("il_done", idx, 16);
        run_commit(il_tid, il_auth, 1'b0);

        // Reset during the second AUTH cycle.
        load_std(8, 8);
        do_xfer(2'b10, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        check("pre_rst_aval", {255'd0, lc_authentication_valid}, 256'd1);
        #1;
        rst = 1'b0;
        #1;
        check("rst_aval", {255'd0, lc_authentication_valid}, 256'd0);
        check("rst_tid_mid", lc_transition_id, 256'd0);
        check("rst_aid_mid", lc_authentication_id, 256'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {252'd0, host_ready, busy, err, lc_transition_request_in}, 256'h8);
        do_xfer(2'b10, 32'h0);
        @(negedge clk);
        check("post_rst_commit", {253'd0, err, err_code}, 256'h6);
        check("post_rst_noreq", {255'd0, lc_transition_request_in}, 256'd0);
        abort_and_wait();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
